// File: rtl/fifo_pkg.sv
// Gray/binary pointer conversion shared by both pointer domains of the async FIFO.
// Callers zero-extend narrower pointers to 32 bits and truncate the result.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended input keeps the upper bits zero, so the width is implicit.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status logic of the async FIFO (wclk domain only).
// wq2_rptr is already synchronized; flags are pessimistic by the sync lag.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin, wbinnext, wgraynext, rbin_s, level_next;
  logic          full_next, afull_next, ovf_next;

  always_comb begin
    // No memory write may be issued while reset is held, whatever winc does.
    wen        = winc & ~wfull & wrst_n;
    wbinnext   = wbin + PW'(wen);
    wgraynext  = PW'(bin2gray(PTR_MAX_W'(wbinnext)));
    rbin_s     = PW'(gray2bin(PTR_MAX_W'(wq2_rptr)));
    level_next = wbinnext - rbin_s;
    full_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    afull_next = (level_next >= PW'(AFULL_THRESH));
    // Set beats clear when both happen in the same cycle.
    ovf_next   = (winc & wfull) | (woverflow & ~wclr_ovf);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wlevel       <= level_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      woverflow    <= ovf_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

endmodule
